// File: rtl/seq_gen_multi.sv
// seq_gen_multi: bus-mapped multi-channel pattern sequencer.
// Plays OUT_BITS-wide steps from byte memory at BUS_CLK/CLKDIV.

module seq_gen_multi #(
  parameter int ABUSWIDTH = 16,
  parameter logic [ABUSWIDTH-1:0] BASEADDR = 16'h1000,
  parameter int OUT_BITS = 8,
  parameter int MEM_BYTES = 1024
) (
  input  logic                 BUS_CLK,
  input  logic                 BUS_RST,
  input  logic [ABUSWIDTH-1:0] BUS_ADD,
  input  logic [7:0]           BUS_DATA_IN,
  output logic [7:0]           BUS_DATA_OUT,
  input  logic                 BUS_RD,
  input  logic                 BUS_WR,
  input  logic                 EXT_START,
  output logic [OUT_BITS-1:0]  SEQ_OUT,
  output logic                 READY,
  output logic                 DONE
);

  localparam int B     = OUT_BITS / 8;
  localparam int STEPS = MEM_BYTES / B;
  localparam int AW    = $clog2(MEM_BYTES);
  localparam int SW    = $clog2(STEPS);

  typedef enum logic {S_IDLE, S_RUN} state_t;
  state_t state;

  logic [7:0]  mem [MEM_BYTES];
  logic [7:0]  clkdiv;
  logic [7:0]  repeat_n;
  logic [15:0] size;
  logic [15:0] rep_start;
  logic        en_ext;

  logic [15:0] nxt;
  logic [7:0]  cnt;
  logic [7:0]  pass;
  logic        last;
  logic        ext_q;

  logic [31:0] add32;
  logic [31:0] off;
  logic        hit;
  logic        reg_hit;
  logic        mem_hit;
  logic [AW-1:0] maddr;
  logic        soft_rst;
  logic        start_wr;
  logic        ext_rise;
  logic        start;

  assign add32    = 32'(BUS_ADD);
  assign off      = add32 - 32'(BASEADDR);
  assign hit      = (add32 >= 32'(BASEADDR)) &&
                    (off < 32'(16 + MEM_BYTES));
  assign reg_hit  = hit && (off < 32'd16);
  assign mem_hit  = hit && !reg_hit;
  assign maddr    = AW'(off - 32'd16);
  assign soft_rst = BUS_WR && reg_hit && (off[3:0] == 4'd0);
  assign start_wr = BUS_WR && reg_hit && (off[3:0] == 4'd1);
  assign ext_rise = en_ext && EXT_START && !ext_q;
  assign start    = start_wr || ext_rise;

  logic [7:0]  div_eff;
  logic [15:0] rs_eff;
  logic        at_end;
  logic        more;

  assign div_eff = (clkdiv == 8'd0) ? 8'd1 : clkdiv;
  assign rs_eff  = (rep_start < size) ? rep_start : 16'd0;
  assign at_end  = (size == 16'd0) || (nxt >= size - 16'd1);
  assign more    = (repeat_n == 8'd0) || (pass < repeat_n);

  logic [SW-1:0]       step_idx;
  logic [OUT_BITS-1:0] fetch;

  assign step_idx = nxt[SW-1:0];

  always_comb begin
    fetch = '0;
    for (int k = 0; k < B; k++)
      fetch[8*k +: 8] = mem[AW'(32'(step_idx) * 32'(B) + 32'(k))];
  end

  logic [7:0] rd_data;

  always_comb begin
    rd_data = 8'd0;
    if (mem_hit) begin
      rd_data = mem[maddr];
    end else if (reg_hit) begin
      unique case (off[3:0])
        4'd1:    rd_data = {7'd0, READY};
        4'd2:    rd_data = clkdiv;
        4'd3:    rd_data = size[15:8];
        4'd4:    rd_data = size[7:0];
        4'd7:    rd_data = repeat_n;
        4'd8:    rd_data = rep_start[15:8];
        4'd9:    rd_data = rep_start[7:0];
        4'd10:   rd_data = {7'd0, en_ext};
        default: rd_data = 8'd0;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) BUS_DATA_OUT <= 8'd0;
    else BUS_DATA_OUT <= (BUS_RD && hit) ? rd_data : 8'd0;
  end

  // pattern memory is deliberately never cleared
  always_ff @(posedge BUS_CLK) begin
    if (BUS_WR && mem_hit) mem[maddr] <= BUS_DATA_IN;
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      clkdiv    <= 8'd1;
      size      <= 16'd0;
      repeat_n  <= 8'd1;
      rep_start <= 16'd0;
      en_ext    <= 1'b0;
    end else if (BUS_WR && reg_hit) begin
      unique case (off[3:0])
        4'd2:    clkdiv          <= BUS_DATA_IN;
        4'd3:    size[15:8]      <= BUS_DATA_IN;
        4'd4:    size[7:0]       <= BUS_DATA_IN;
        4'd7:    repeat_n        <= BUS_DATA_IN;
        4'd8:    rep_start[15:8] <= BUS_DATA_IN;
        4'd9:    rep_start[7:0]  <= BUS_DATA_IN;
        4'd10:   en_ext          <= BUS_DATA_IN[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge BUS_CLK) begin
    if (BUS_RST) begin
      state   <= S_IDLE;
      SEQ_OUT <= '0;
      READY   <= 1'b1;
      DONE    <= 1'b0;
      nxt     <= 16'd0;
      cnt     <= 8'd0;
      pass    <= 8'd0;
      last    <= 1'b0;
      ext_q   <= 1'b0;
    end else begin
      ext_q <= EXT_START;
      DONE  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start && size != 16'd0) begin
            state <= S_RUN;
            READY <= 1'b0;
            nxt   <= 16'd0;
            cnt   <= 8'd0;
            pass  <= 8'd1;
            last  <= 1'b0;
          end
        end
        S_RUN: begin
          if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else if (last) begin
            state   <= S_IDLE;
            SEQ_OUT <= '0;
            READY   <= 1'b1;
            DONE    <= 1'b1;
          end else begin
            SEQ_OUT <= fetch;
            cnt     <= div_eff - 8'd1;
            if (!at_end) begin
              nxt <= nxt + 16'd1;
            end else if (more) begin
              nxt <= rs_eff;
              if (repeat_n != 8'd0) pass <= pass + 8'd1;
            end else begin
              last <= 1'b1;
            end
          end
        end
      endcase
      if (soft_rst) begin
        state   <= S_IDLE;
        SEQ_OUT <= '0;
        READY   <= 1'b1;
        DONE    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_gen_multi.sv
// tb_seq_gen_multi: randomized bench for seq_gen_multi,
// checked against a per-cycle trace built from the step rules.

module tb_seq_gen_multi;

  localparam int OB = 16;
  localparam int MB = 1024;
  localparam int B  = OB / 8;
  localparam logic [15:0] BASE = 16'h1000;

  logic          BUS_CLK = 1'b0;
  logic          BUS_RST = 1'b1;
  logic [15:0]   BUS_ADD = '0;
  logic [7:0]    BUS_DATA_IN = '0;
  logic [7:0]    BUS_DATA_OUT;
  logic          BUS_RD = 1'b0;
  logic          BUS_WR = 1'b0;
  logic          EXT_START = 1'b0;
  logic [OB-1:0] SEQ_OUT;
  logic          READY;
  logic          DONE;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] mm [MB];
  int m_div  = 1;
  int m_size = 0;
  int m_rep  = 1;
  int m_rs   = 0;
  int m_en   = 0;
  logic [OB+1:0] exp_q[$];

  seq_gen_multi #(
    .ABUSWIDTH(16),
    .BASEADDR(BASE),
    .OUT_BITS(OB),
    .MEM_BYTES(MB)
  ) dut (
    .BUS_CLK(BUS_CLK),
    .BUS_RST(BUS_RST),
    .BUS_ADD(BUS_ADD),
    .BUS_DATA_IN(BUS_DATA_IN),
    .BUS_DATA_OUT(BUS_DATA_OUT),
    .BUS_RD(BUS_RD),
    .BUS_WR(BUS_WR),
    .EXT_START(EXT_START),
    .SEQ_OUT(SEQ_OUT),
    .READY(READY),
    .DONE(DONE)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic bus_wr(input int off, input logic [7:0] d);
    @(negedge BUS_CLK);
    BUS_ADD = BASE + 16'(off);
    BUS_DATA_IN = d;
    BUS_WR = 1'b1;
    @(negedge BUS_CLK);
    BUS_WR = 1'b0;
    if (off >= 16) mm[off-16] = d;
  endtask

  task automatic bus_rd(input int off, output logic [7:0] d);
    @(negedge BUS_CLK);
    BUS_ADD = BASE + 16'(off);
    BUS_RD = 1'b1;
    @(negedge BUS_CLK);
    BUS_RD = 1'b0;
    d = BUS_DATA_OUT;
  endtask

  task automatic cfg(input int dv, input int sz, input int rp,
                     input int rs, input int en);
    bus_wr(2, 8'(dv));
    bus_wr(3, 8'(sz >> 8));
    bus_wr(4, 8'(sz));
    bus_wr(7, 8'(rp));
    bus_wr(8, 8'(rs >> 8));
    bus_wr(9, 8'(rs));
    bus_wr(10, 8'(en));
    m_div = dv; m_size = sz; m_rep = rp; m_rs = rs; m_en = en;
  endtask

  function automatic logic [OB-1:0] step_val(input int s);
    logic [OB-1:0] v;
    v = '0;
    for (int k = 0; k < B; k++) v[8*k +: 8] = mm[s*B + k];
    return v;
  endfunction

  // expected {SEQ_OUT,READY,DONE} per cycle, from the cycle after start
  task automatic build(input int maxlen);
    int de;
    int rse;
    de  = (m_div == 0) ? 1 : m_div;
    rse = (m_rs >= m_size) ? 0 : m_rs;
    exp_q.delete();
    exp_q.push_back({{OB{1'b0}}, 2'b00});
    for (int p = 1; m_rep == 0 || p <= m_rep; p++)
      for (int s = (p == 1) ? 0 : rse; s < m_size; s++)
        for (int d = 0; d < de; d++) begin
          exp_q.push_back({step_val(s), 2'b00});
          if (exp_q.size() >= maxlen) return;
        end
    exp_q.push_back({{OB{1'b0}}, 2'b11});
    exp_q.push_back({{OB{1'b0}}, 2'b10});
  endtask

  // kind: 0 START write, 1 EXT_START edge, 2 both in one cycle
  task automatic run_seq(input int kind, input int maxlen,
                         input int poke_at);
    build(maxlen);
    @(negedge BUS_CLK);
    if (kind != 0) EXT_START = 1'b1;
    if (kind != 1) begin
      BUS_ADD = BASE + 16'd1;
      BUS_DATA_IN = 8'h01;
      BUS_WR = 1'b1;
    end
    @(negedge BUS_CLK);
    EXT_START = 1'b0;
    BUS_WR = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i == poke_at) begin
        EXT_START = 1'b1;
        BUS_ADD = BASE + 16'd1;
        BUS_DATA_IN = 8'h01;
        BUS_WR = 1'b1;
      end else if (i == poke_at + 1) begin
        EXT_START = 1'b0;
        BUS_WR = 1'b0;
      end
      chk("trace", 32'({SEQ_OUT, READY, DONE}), 32'(exp_q[i]));
      @(negedge BUS_CLK);
    end
    EXT_START = 1'b0;
    BUS_WR = 1'b0;
  endtask

  task automatic abort_run();
    logic [7:0] d;
    bus_rd(1, d);
    chk("ready_rd_run", 32'(d), 32'd0);
    bus_wr(0, 8'h00);
    for (int i = 0; i < 4; i++) begin
      chk("after_soft_rst", 32'({SEQ_OUT, READY, DONE}),
          32'({{OB{1'b0}}, 2'b10}));
      @(negedge BUS_CLK);
    end
  endtask

  task automatic idle_hold(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk(tag, 32'({SEQ_OUT, READY, DONE}),
          32'({{OB{1'b0}}, 2'b10}));
      @(negedge BUS_CLK);
    end
  endtask

  initial begin
    logic [7:0] d;
    int offs[8];
    int defs[8];
    int kind;
    int poke;
    offs = '{1, 2, 3, 4, 7, 8, 9, 10};
    defs = '{1, 1, 0, 0, 1, 0, 0, 0};

    repeat (3) @(negedge BUS_CLK);
    BUS_RST = 1'b0;
    @(negedge BUS_CLK);
    chk("rst_seq_out", 32'(SEQ_OUT), 32'd0);
    chk("rst_ready", 32'(READY), 32'd1);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_dout", 32'(BUS_DATA_OUT), 32'd0);
    for (int i = 0; i < 8; i++) begin
      bus_rd(offs[i], d);
      chk($sformatf("rst_reg%0d", offs[i]), 32'(d), 32'(defs[i]));
    end

    // long run, one nonzero step
    for (int i = 0; i < 128 * B; i++) bus_wr(16 + i, 8'h00);
    bus_wr(16 + B, 8'h01);
    cfg(8, 128, 1, 0, 0);
    run_seq(0, 1 << 20, -1);
    bus_rd(16 + B, d);
    chk("mem_rd", 32'(d), 32'd1);

    // partial repeat
    for (int i = 0; i < 16; i++) begin
      bus_wr(16 + i*B, 8'(i + 1));
      bus_wr(16 + i*B + 1, 8'h00);
    end
    cfg(1, 16, 2, 1, 0);
    run_seq(0, 1 << 20, -1);

    // infinite repeat, aborted by soft reset
    cfg(3, 4, 0, 0, 0);
    run_seq(0, 1200, -1);
    abort_run();

    // 16-bit step byte order, SIZE=0 start ignored
    bus_wr(16, 8'h34);
    bus_wr(17, 8'h12);
    cfg(2, 1, 1, 0, 0);
    run_seq(0, 1 << 20, -1);
    cfg(2, 0, 1, 0, 0);
    bus_wr(1, 8'h01);
    idle_hold("size0_idle");

    // external start, retrigger ignored, disabled edge ignored
    cfg(2, 5, 1, 0, 1);
    run_seq(1, 1 << 20, 3);
    cfg(2, 5, 1, 0, 0);
    @(negedge BUS_CLK);
    EXT_START = 1'b1;
    @(negedge BUS_CLK);
    EXT_START = 1'b0;
    idle_hold("ext_disabled");

    for (int r = 0; r < 24; r++) begin
      int sz;
      sz = $urandom_range(1, 10);
      for (int i = 0; i < sz * B; i++)
        bus_wr(16 + i, 8'($urandom));
      cfg($urandom_range(0, 4), sz, $urandom_range(0, 3),
          $urandom_range(0, sz + 1), $urandom_range(0, 1));
      kind = (m_en != 0) ? $urandom_range(0, 2) : 0;
      poke = $urandom_range(0, 3) == 0 ? 2 : -1;
      if (m_rep == 0) begin
        run_seq(kind, $urandom_range(20, 80), poke);
        abort_run();
      end else begin
        run_seq(kind, 1 << 20, poke);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
